fifo_pop_arbiter: RTL and testbench
===================================

FIFO_POP_ARBITER -- requirements
Module: fifo_pop_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4: number of FIFO requesters (2..16).
REQ-002 SHALL have parameter WIDTH, default 32: data width per requester.
REQ-003 SHALL have parameter BURST, default 4: max consecutive pops granted to one requester (1..255).
REQ-004 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port i_empty  input  N_REQ  per-requester FIFO empty flag (FWFT FIFO, registered flag).
REQ-007 SHALL have port o_pop  output  N_REQ  per-requester pop strobe, at most one bit high.
REQ-008 SHALL have port i_rdata  input  N_REQ*WIDTH  concatenated FWFT head data, requester k at bits [k*WIDTH +: WIDTH].
REQ-009 SHALL have port o_valid  output  1  output register holds a word.
REQ-010 SHALL have port i_ready  input  1  downstream accepts; transfer when o_valid && i_ready.
REQ-011 SHALL have port o_data  output  WIDTH  output word.
REQ-012 SHALL have port o_src  output  $clog2(N_REQ)  requester index of o_data.
REQ-013 SHALL have port i_stats_clr  input  1  clears grant counters.
REQ-014 SHALL have port o_grant_cnt  output  N_REQ*16  per-requester grant counters.

Function
REQ-015 SHALL be able to pop (slot free) when !o_valid or (o_valid && i_ready).
REQ-016 SHALL assert o_pop[k] only when slot free and !i_empty[k] and k is the selected requester; never pop an empty FIFO.
REQ-017 SHALL, on o_pop[k], load o_data <= i_rdata[k], o_src <= k, o_valid <= 1 at the same edge (1-cycle pop-to-valid latency).
REQ-018 SHALL clear o_valid on transfer when no pop occurs that cycle; transfer plus pop SHALL keep o_valid high (full throughput, one word per cycle).
REQ-019 SHALL hold o_data/o_src/o_valid stable while o_valid && !i_ready.
REQ-020 SHALL run FSM IDLE/LOCK: IDLE selects by round-robin, searching from (last_grant+1) mod N_REQ upward with wrap, first non-empty wins.
REQ-021 SHALL, on a pop from IDLE, record owner=k, last_grant=k, burst_cnt=1; go LOCK if BURST>1, else stay IDLE.
REQ-022 SHALL in LOCK select only owner; on pop increment burst_cnt; return to IDLE when burst_cnt reaches BURST, or when slot free and i_empty[owner]=1 (no pop that cycle from LOCK; re-arbitration next cycle).
REQ-023 SHALL leave LOCK state and counters unchanged while slot not free.
REQ-024 SHALL produce no pop when all i_empty bits are 1; last_grant unchanged.
REQ-025 SHALL treat X on i_empty/i_ready as a simulation assertion failure under SIMULATION.

Reset
REQ-026 SHALL, on rst_n low (async assert, sync deassert externally), force o_valid=0, o_pop=0, o_data=0, o_src=0, FSM=IDLE, burst_cnt=0, last_grant=N_REQ-1 (first search starts at 0), counters=0.
REQ-027 SHALL discard any held output word on reset mid-transfer; no pop SHALL issue in the reset-release cycle's preceding edge.

Configuration
REQ-028 SHALL compile grant counters only when FIFO_POP_ARB_STATS_EN is defined: each 16-bit counter increments on its o_pop, saturates at 0xFFFF, i_stats_clr wins over increment.
REQ-029 SHALL, without FIFO_POP_ARB_STATS_EN, keep i_stats_clr/o_grant_cnt ports, ignore i_stats_clr, drive o_grant_cnt to 0.

Structure
REQ-030 SHALL place FSM state enum (ARB_IDLE, ARB_LOCK) and counter width constant (STAT_W=16) in package fifo_pop_arb_pkg.
REQ-031 SHALL implement round-robin selection in sub-module rr_pick (combinational: request vector, last index -> one-hot grant, index, any).

Verification
REQ-032 SHALL verify: N_REQ=4, BURST=1, all non-empty, i_ready=1 -> o_src sequence 0,1,2,3,0 with o_valid high every cycle after first.
REQ-033 SHALL verify: BURST=4, req0 has 6 words, req2 has 2, i_ready=1 -> o_src 0,0,0,0,2,2,0,0.
REQ-034 SHALL verify: i_ready=0 for 5 cycles with o_valid=1 -> o_pop stays 0, o_data stable, then one transfer per cycle resumes.
REQ-035 SHALL verify: owner req1 empties after 2 of BURST=4 -> exactly one idle-pop cycle, then req3 granted next.
REQ-036 SHALL verify: rst_n pulsed low mid-burst with o_valid=1 -> o_valid=0 immediately, after release first grant goes to req0.
REQ-037 SHALL verify (STATS_EN): 70000 pops from req0 -> o_grant_cnt[0]=0xFFFF; i_stats_clr pulse -> 0.

Source files
------------

// File: rtl/fifo_pop_arb_pkg.sv
// Shared FSM state type and counter widths for fifo_pop_arbiter.
package fifo_pop_arb_pkg;

   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_LOCK = 1'b1
   } arb_state_t;

   localparam int STAT_W = 16;
   // Wide enough for the largest allowed burst length of 255.
   localparam int BCNT_W = 8;

endpackage

// File: rtl/fifo_pop_arbiter_rr_pick.sv
// Round-robin pick: first requester set at or after (last_i+1) mod N, with wrap.
// Purely combinational; no backpressure.
module rr_pick
   import fifo_pop_arb_pkg::*;
#(
   parameter  int N  = 4,
   localparam int IW = $clog2(N)
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] last_i,
   output logic [N-1:0]  grant_o,
   output logic [IW-1:0] idx_o,
   output logic          any_o
);

   always_comb begin
      logic [IW-1:0] cand;
      grant_o = '0;
      idx_o   = '0;
      any_o   = 1'b0;
      cand    = '0;
      for (int i = 1; i <= N; i++) begin
         cand = IW'((int'(last_i) + i) % N);
         if (!any_o && req_i[cand]) begin
            any_o = 1'b1;
            idx_o = cand;
         end
      end
      if (any_o) grant_o[idx_o] = 1'b1;
   end

endmodule

// File: rtl/fifo_pop_arbiter.sv
// Pops FWFT FIFOs round-robin with per-owner bursts into one output register; pop-to-valid 1 cycle.
// Pops only when the output slot is free (empty or draining); holds word while !i_ready.
// Grant counters are built only with FIFO_POP_ARB_STATS_EN defined.
module fifo_pop_arbiter
   import fifo_pop_arb_pkg::*;
#(
   parameter  int N_REQ = 4,
   parameter  int WIDTH = 32,
   parameter  int BURST = 4,
   localparam int IW    = $clog2(N_REQ)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [N_REQ-1:0]        i_empty,
   output logic [N_REQ-1:0]        o_pop,
   input  logic [N_REQ*WIDTH-1:0]  i_rdata,
   output logic                    o_valid,
   input  logic                    i_ready,
   output logic [WIDTH-1:0]        o_data,
   output logic [IW-1:0]           o_src,
   input  logic                    i_stats_clr,
   output logic [N_REQ*STAT_W-1:0] o_grant_cnt
);

   arb_state_t        state_q;
   logic [IW-1:0]     owner_q;
   logic [IW-1:0]     last_q;
   logic [BCNT_W-1:0] burst_cnt_q;
   logic              valid_q;
   logic [WIDTH-1:0]  data_q;
   logic [IW-1:0]     src_q;

   logic [N_REQ-1:0]  rr_grant;
   logic [IW-1:0]     rr_idx;
   logic              rr_any;
   logic [N_REQ-1:0]  sel_onehot;
   logic [IW-1:0]     sel_idx;
   logic              sel_any;
   logic              slot_free;
   logic              pop;
   logic              burst_done;

   rr_pick #(.N(N_REQ)) u_rr_pick (
      .req_i   (~i_empty),
      .last_i  (last_q),
      .grant_o (rr_grant),
      .idx_o   (rr_idx),
      .any_o   (rr_any)
   );

   // While locked only the owner may be popped, even if others have data.
   always_comb begin
      sel_idx    = rr_idx;
      sel_any    = rr_any;
      sel_onehot = rr_grant;
      if (state_q == ARB_LOCK) begin
         sel_idx             = owner_q;
         sel_any             = !i_empty[owner_q];
         sel_onehot          = '0;
         sel_onehot[owner_q] = 1'b1;
      end
   end

   assign slot_free  = !valid_q || i_ready;
   assign pop        = slot_free && sel_any;
   assign o_pop      = (pop && rst_n) ? sel_onehot : '0;
   assign burst_done = (burst_cnt_q + 1'b1) == BCNT_W'(BURST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ARB_IDLE;
         owner_q     <= '0;
         last_q      <= IW'(N_REQ - 1);
         burst_cnt_q <= '0;
         valid_q     <= 1'b0;
         data_q      <= '0;
         src_q       <= '0;
      end else begin
         if (pop) begin
            valid_q <= 1'b1;
            data_q  <= i_rdata[int'(sel_idx)*WIDTH +: WIDTH];
            src_q   <= sel_idx;
         end else if (valid_q && i_ready) begin
            valid_q <= 1'b0;
         end

         if (slot_free) begin
            if (state_q == ARB_IDLE) begin
               if (rr_any) begin
                  owner_q     <= rr_idx;
                  last_q      <= rr_idx;
                  burst_cnt_q <= BCNT_W'(1);
                  state_q     <= (BURST > 1) ? ARB_LOCK : ARB_IDLE;
               end
            end else if (sel_any) begin
               burst_cnt_q <= burst_cnt_q + 1'b1;
               if (burst_done) state_q <= ARB_IDLE;
            end else begin
               // Owner ran dry: give up the lock, re-arbitrate next cycle.
               state_q <= ARB_IDLE;
            end
         end
      end
   end

   assign o_valid = valid_q;
   assign o_data  = data_q;
   assign o_src   = src_q;

`ifdef FIFO_POP_ARB_STATS_EN
   logic [STAT_W-1:0] cnt_q [N_REQ];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < N_REQ; k++) cnt_q[k] <= '0;
      end else begin
         for (int k = 0; k < N_REQ; k++) begin
            if (i_stats_clr)                    cnt_q[k] <= '0;
            else if (o_pop[k] && cnt_q[k] != '1) cnt_q[k] <= cnt_q[k] + 1'b1;
         end
      end
   end

   for (genvar k = 0; k < N_REQ; k++) begin : g_cnt
      assign o_grant_cnt[k*STAT_W +: STAT_W] = cnt_q[k];
   end
`else
   logic unused_stats_clr;
   assign unused_stats_clr = i_stats_clr;
   assign o_grant_cnt      = '0;
`endif

`ifdef SIMULATION
   always @(posedge clk) begin
      if (rst_n) assert (!$isunknown({i_empty, i_ready}));
   end
`endif

endmodule

// File: tb/tb_fifo_pop_arbiter.sv
// Bench for fifo_pop_arbiter: BURST=4 and BURST=1 instances against a queue-based reference.
module tb_fifo_pop_arbiter;
   localparam int N = 4;
   localparam int W = 32;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic           rst_n;
   logic           stats_clr;
   logic [N-1:0]   i_empty_a [2];
   logic [N*W-1:0] i_rdata_a [2];
   logic [N-1:0]   o_pop_a   [2];
   logic           o_valid_a [2];
   logic           rdy       [2];
   logic [W-1:0]   o_data_a  [2];
   logic [1:0]     o_src_a   [2];
   logic [N*16-1:0] o_cnt_a  [2];

   fifo_pop_arbiter #(.N_REQ(N), .WIDTH(W), .BURST(4)) dut (
      .clk(clk), .rst_n(rst_n), .i_empty(i_empty_a[0]), .o_pop(o_pop_a[0]),
      .i_rdata(i_rdata_a[0]), .o_valid(o_valid_a[0]), .i_ready(rdy[0]),
      .o_data(o_data_a[0]), .o_src(o_src_a[0]), .i_stats_clr(stats_clr),
      .o_grant_cnt(o_cnt_a[0]));

   fifo_pop_arbiter #(.N_REQ(N), .WIDTH(W), .BURST(1)) dut_b1 (
      .clk(clk), .rst_n(rst_n), .i_empty(i_empty_a[1]), .o_pop(o_pop_a[1]),
      .i_rdata(i_rdata_a[1]), .o_valid(o_valid_a[1]), .i_ready(rdy[1]),
      .o_data(o_data_a[1]), .o_src(o_src_a[1]), .i_stats_clr(stats_clr),
      .o_grant_cnt(o_cnt_a[1]));

   // Reference: FIFO contents as queues, arbitration as plain integers.
   logic [W-1:0] fq [2][N][$];
   int           burst_len [2] = '{4, 1};
   int           m_last [2];
   int           m_owner [2];
   int           m_cnt [2];
   bit           m_lock [2];
   bit           m_valid [2];
   logic [W-1:0] m_data [2];
   int           m_src [2];
   int           m_stat [2][N];
   int           xfer [2][$];
   logic [N-1:0] popv [2][$];
   int           n_checks;
   int           n_fail;

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         m_last[d] = N - 1; m_owner[d] = 0; m_cnt[d] = 0; m_lock[d] = 0;
         m_valid[d] = 0; m_data[d] = '0; m_src[d] = 0;
         for (int k = 0; k < N; k++) m_stat[d][k] = 0;
      end
   endtask

   task automatic drive();
      for (int d = 0; d < 2; d++)
         for (int k = 0; k < N; k++) begin
            i_empty_a[d][k] = (fq[d][k].size() == 0);
            i_rdata_a[d][k*W +: W] = (fq[d][k].size() != 0) ? fq[d][k][0] : '0;
         end
   endtask

   task automatic model_step(input int d, output logic [N-1:0] exp_pop);
      int pick;
      int k;
      pick = -1;
      exp_pop = '0;
      if (!m_valid[d] || rdy[d]) begin
         if (m_lock[d]) begin
            if (fq[d][m_owner[d]].size() != 0) begin
               pick = m_owner[d];
               m_cnt[d]++;
               if (m_cnt[d] >= burst_len[d]) m_lock[d] = 0;
            end else begin
               m_lock[d] = 0;
            end
         end else begin
            for (int j = 1; j <= N; j++) begin
               k = (m_last[d] + j) % N;
               if (pick < 0 && fq[d][k].size() != 0) pick = k;
            end
            if (pick >= 0) begin
               m_last[d] = pick; m_owner[d] = pick; m_cnt[d] = 1;
               m_lock[d] = (burst_len[d] > 1);
            end
         end
      end
      if (stats_clr) begin
         for (int i = 0; i < N; i++) m_stat[d][i] = 0;
      end else if (pick >= 0 && m_stat[d][pick] < 65535) begin
         m_stat[d][pick]++;
      end
      if (pick >= 0) begin
         exp_pop[pick] = 1'b1;
         m_valid[d] = 1;
         m_data[d] = fq[d][pick].pop_front();
         m_src[d] = pick;
      end else if (rdy[d]) begin
         m_valid[d] = 0;
      end
   endtask

   task automatic cycle();
      logic [N-1:0] ep [2];
      drive();
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         n_checks++;
         if (o_valid_a[d] !== m_valid[d]) begin
            n_fail++; $display("FAIL valid[%0d]: got %0b want %0b", d, o_valid_a[d], m_valid[d]);
         end
         if (m_valid[d]) begin
            n_checks += 2;
            if (o_data_a[d] !== m_data[d]) begin
               n_fail++; $display("FAIL data[%0d]: got %0h want %0h", d, o_data_a[d], m_data[d]);
            end
            if (o_src_a[d] !== 2'(m_src[d])) begin
               n_fail++; $display("FAIL src[%0d]: got %0d want %0d", d, o_src_a[d], m_src[d]);
            end
         end
         if (o_valid_a[d] && rdy[d]) xfer[d].push_back(int'(o_src_a[d]));
         popv[d].push_back(o_pop_a[d]);
         model_step(d, ep[d]);
         n_checks++;
         if (o_pop_a[d] !== ep[d]) begin
            n_fail++; $display("FAIL pop[%0d]: got %b want %b", d, o_pop_a[d], ep[d]);
         end
      end
      @(posedge clk);
      #1;
      drive();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      for (int d = 0; d < 2; d++) begin
         n_checks += 2;
         if (o_valid_a[d] !== 1'b0) begin
            n_fail++; $display("FAIL reset_valid[%0d]: got %0b want 0", d, o_valid_a[d]);
         end
         if (o_pop_a[d] !== '0) begin
            n_fail++; $display("FAIL reset_pop[%0d]: got %b want 0000", d, o_pop_a[d]);
         end
      end
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic drain();
      bit done;
      done = 0;
      rdy[0] = 1'b1; rdy[1] = 1'b1;
      for (int i = 0; i < 300 && !done; i++) begin
         done = !m_valid[0] && !m_valid[1];
         for (int d = 0; d < 2; d++)
            for (int k = 0; k < N; k++) if (fq[d][k].size() != 0) done = 0;
         if (!done) cycle();
      end
      n_checks++;
      if (!done) begin
         n_fail++; $display("FAIL drain: got busy want idle within 300 cycles");
      end
   endtask

   task automatic test_reset();
      for (int d = 0; d < 2; d++) begin
         n_checks += 5;
         if (o_valid_a[d] !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %0b want 0", o_valid_a[d]); end
         if (o_data_a[d] !== '0) begin n_fail++; $display("FAIL rst_data: got %0h want 0", o_data_a[d]); end
         if (o_src_a[d] !== '0) begin n_fail++; $display("FAIL rst_src: got %0d want 0", o_src_a[d]); end
         if (o_pop_a[d] !== '0) begin n_fail++; $display("FAIL rst_pop: got %b want 0", o_pop_a[d]); end
         if (o_cnt_a[d] !== '0) begin n_fail++; $display("FAIL rst_cnt: got %0h want 0", o_cnt_a[d]); end
      end
      repeat (2) cycle();
   endtask

   task automatic test_round_robin();
      int exp_src [5] = '{0, 1, 2, 3, 0};
      for (int k = 0; k < N; k++) repeat (3) fq[1][k].push_back($urandom);
      xfer[1].delete();
      repeat (6) cycle();
      n_checks++;
      if (xfer[1].size() != 5) begin
         n_fail++; $display("FAIL rr_count: got %0d want 5", xfer[1].size());
      end else begin
         for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (xfer[1][i] != exp_src[i]) begin
               n_fail++; $display("FAIL rr_src[%0d]: got %0d want %0d", i, xfer[1][i], exp_src[i]);
            end
         end
      end
      drain();
   endtask

   task automatic test_burst();
      int exp_src [8] = '{0, 0, 0, 0, 2, 2, 0, 0};
      repeat (6) fq[0][0].push_back($urandom);
      repeat (2) fq[0][2].push_back($urandom);
      xfer[0].delete();
      repeat (12) cycle();
      n_checks++;
      if (xfer[0].size() != 8) begin
         n_fail++; $display("FAIL burst_count: got %0d want 8", xfer[0].size());
      end else begin
         for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (xfer[0][i] != exp_src[i]) begin
               n_fail++; $display("FAIL burst_src[%0d]: got %0d want %0d", i, xfer[0][i], exp_src[i]);
            end
         end
      end
      drain();
   endtask

   task automatic test_backpressure();
      logic [W-1:0] first;
      first = $urandom;
      fq[0][1].push_back(first);
      repeat (7) fq[0][1].push_back($urandom);
      rdy[0] = 1'b0;
      cycle();
      popv[0].delete();
      repeat (5) begin
         cycle();
         n_checks += 2;
         if (o_valid_a[0] !== 1'b1) begin n_fail++; $display("FAIL bp_valid: got %0b want 1", o_valid_a[0]); end
         if (o_data_a[0] !== first) begin n_fail++; $display("FAIL bp_data: got %0h want %0h", o_data_a[0], first); end
      end
      for (int i = 0; i < 5; i++) begin
         n_checks++;
         if (popv[0][i] !== '0) begin n_fail++; $display("FAIL bp_pop[%0d]: got %b want 0000", i, popv[0][i]); end
      end
      rdy[0] = 1'b1;
      xfer[0].delete();
      repeat (4) cycle();
      n_checks++;
      if (xfer[0].size() != 4) begin
         n_fail++; $display("FAIL bp_resume: got %0d want 4", xfer[0].size());
      end
      drain();
   endtask

   task automatic test_owner_empties();
      logic [N-1:0] exp_pop [4] = '{4'b0010, 4'b0010, 4'b0000, 4'b1000};
      do_reset();
      repeat (2) fq[0][1].push_back($urandom);
      repeat (4) fq[0][3].push_back($urandom);
      popv[0].delete();
      repeat (4) cycle();
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (popv[0][i] !== exp_pop[i]) begin
            n_fail++; $display("FAIL owner_pop[%0d]: got %b want %b", i, popv[0][i], exp_pop[i]);
         end
      end
      drain();
   endtask

   task automatic test_reset_mid_burst();
      repeat (6) fq[0][2].push_back($urandom);
      repeat (2) cycle();
      n_checks++;
      if (o_valid_a[0] !== 1'b1) begin n_fail++; $display("FAIL mid_valid: got %0b want 1", o_valid_a[0]); end
      repeat (4) fq[0][0].push_back($urandom);
      do_reset();
      popv[0].delete();
      cycle();
      n_checks++;
      if (popv[0][0] !== 4'b0001) begin
         n_fail++; $display("FAIL mid_first_grant: got %b want 0001", popv[0][0]);
      end
      drain();
   endtask

   task automatic test_random();
      repeat (1500) begin
         for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < N; k++)
               if ($urandom_range(0, 3) == 0 && fq[d][k].size() < 4) fq[d][k].push_back($urandom);
            rdy[d] = ($urandom_range(0, 3) != 0);
         end
         cycle();
      end
      drain();
      for (int d = 0; d < 2; d++)
         for (int k = 0; k < N; k++) begin
            logic [15:0] want;
`ifdef FIFO_POP_ARB_STATS_EN
            want = 16'(m_stat[d][k]);
`else
            want = '0;
`endif
            n_checks++;
            if (o_cnt_a[d][k*16 +: 16] !== want) begin
               n_fail++; $display("FAIL cnt[%0d][%0d]: got %0h want %0h", d, k, o_cnt_a[d][k*16 +: 16], want);
            end
         end
   endtask

   task automatic test_stats();
`ifdef FIFO_POP_ARB_STATS_EN
      do_reset();
      repeat (70000) begin
         while (fq[1][0].size() < 2) fq[1][0].push_back($urandom);
         cycle();
      end
      drain();
      n_checks++;
      if (o_cnt_a[1][15:0] !== 16'hFFFF) begin
         n_fail++; $display("FAIL cnt_sat: got %0h want ffff", o_cnt_a[1][15:0]);
      end
`else
      repeat (3) fq[0][0].push_back($urandom);
      repeat (3) cycle();
`endif
      stats_clr = 1'b1;
      cycle();
      stats_clr = 1'b0;
      drain();
      n_checks++;
      if (o_cnt_a[1] !== '0 || o_cnt_a[0] !== '0) begin
         n_fail++; $display("FAIL cnt_clr: got %0h/%0h want 0", o_cnt_a[0], o_cnt_a[1]);
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail = 0;
      rst_n = 1'b0;
      stats_clr = 1'b0;
      rdy[0] = 1'b1;
      rdy[1] = 1'b1;
      model_reset();
      drive();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      test_reset();
      test_round_robin();
      test_burst();
      test_backpressure();
      test_owner_empties();
      test_reset_mid_burst();
      test_random();
      test_stats();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
